dec_sel_arb: RTL and testbench

//   Round-robin arbiter that drives the select/enable inputs of the 2-to-4 output decoder (dec).

---
 rtl/dec_pkg.sv | 13 +
 rtl/dec_sel_arb_if.sv | 30 +++
 rtl/rr_pick4.sv | 27 ++
 rtl/dec_sel_arb.sv | 105 ++++++++++
 tb/tb_dec_sel_arb.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/dec_pkg.sv
// rtl/dec_pkg.sv - shared types and sizes for the decoder select arbiter
package dec_pkg;

  localparam int SEL_W = 2;
  localparam int N_CH  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/dec_sel_arb_if.sv
// rtl/dec_sel_arb_if.sv - request/grant bundle between requesters and the decoder arbiter
interface dec_sel_arb_if;
  import dec_pkg::*;

  logic [N_CH-1:0] req;
  logic            done;
  logic            en;
  logic            a0;
  logic            a1;
  logic            timeout;

  modport master (
    output req,
    output done,
    input  en,
    input  a0,
    input  a1,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output en,
    output a0,
    output a1,
    output timeout
  );

endinterface

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational round-robin pick of four requests
// Scans last+1, last+2, ... (mod 4) and returns the first set request.
module rr_pick4
  import dec_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] idx,
  output logic             valid
);

  logic [SEL_W-1:0] ch;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    ch    = '0;
    for (int k = 1; k <= N_CH; k++) begin
      ch = last + SEL_W'(k);
      if (!valid && req[ch]) begin
        idx   = ch;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dec_sel_arb.sv
// rtl/dec_sel_arb.sv - round-robin arbiter driving the 2-to-4 decoder select/enable
// One grant at a time with a dead cycle between grants so d0..d3 break before make.
module dec_sel_arb
  import dec_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  dec_sel_arb_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_t           state, state_nx;
  logic             en_q, en_nx;
  logic             to_q, to_nx;
  logic [SEL_W-1:0] sel_q, sel_nx;
  logic [SEL_W-1:0] last_q, last_nx;
  logic [CNT_W-1:0] hold_q, hold_nx;

  logic [SEL_W-1:0] pick_idx;
  logic             pick_valid;
  logic             limit_hit;
  logic             owner_req;
  logic             release_now;

  rr_pick4 u_pick (
    .req   (bus.req),
    .last  (last_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign limit_hit   = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
  assign owner_req   = bus.req[sel_q];
  assign release_now = bus.done || !owner_req || limit_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    en_nx    = 1'b0;
    to_nx    = 1'b0;
    sel_nx   = sel_q;
    last_nx  = last_q;
    hold_nx  = hold_q;
    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          state_nx = ST_GRANT;
          en_nx    = 1'b1;
          sel_nx   = pick_idx;
          hold_nx  = '0;
        end
      end
      ST_GRANT: begin
        en_nx   = 1'b1;
        hold_nx = (hold_q == '1) ? hold_q : hold_q + 1'b1;
        if (release_now) begin
          state_nx = ST_GAP;
          en_nx    = 1'b0;
          last_nx  = sel_q;
          // Flag a timeout only when the hold limit alone forced the release.
          to_nx    = limit_hit && !bus.done && owner_req;
        end
      end
      ST_GAP: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      to_q   <= 1'b0;
      sel_q  <= '0;
      last_q <= SEL_W'(N_CH - 1);
      hold_q <= '0;
    end else begin
      en_q   <= en_nx;
      to_q   <= to_nx;
      sel_q  <= sel_nx;
      last_q <= last_nx;
      hold_q <= hold_nx;
    end
  end

  assign bus.en      = en_q;
  assign bus.a0      = sel_q[0];
  assign bus.a1      = sel_q[1];
  assign bus.timeout = to_q;

endmodule

// File: tb/tb_dec_sel_arb.sv
// tb/tb_dec_sel_arb.sv - directed bench for dec_sel_arb with MAX_HOLD=4
module tb_dec_sel_arb;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  dec_sel_arb_if bus ();

  dec_sel_arb #(
    .MAX_HOLD (4),
    .CNT_W    (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic       en;
    logic [1:0] sel;
    logic       to;
  } vec_t;

  localparam int NV = 23;
  vec_t vt [NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  function automatic int cur_sel();
    return int'({bus.a1, bus.a0});
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hi;
    int exp_g [5];

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.req  = 4'b0000;
    bus.done = 1'b0;

    //           rst   req      done  en    sel   to
    vt[0]  = '{1'b0, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0};
    vt[1]  = '{1'b0, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0};
    vt[2]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0};
    vt[3]  = '{1'b1, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b0};
    vt[4]  = '{1'b1, 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0};
    vt[5]  = '{1'b1, 4'b0100, 1'b1, 1'b0, 2'd2, 1'b0};
    vt[6]  = '{1'b1, 4'b0100, 1'b0, 1'b0, 2'd2, 1'b0};
    vt[7]  = '{1'b1, 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0};
    vt[8]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'd2, 1'b0};
    vt[9]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'd2, 1'b0};
    vt[10] = '{1'b1, 4'b0001, 1'b0, 1'b1, 2'd0, 1'b0};
    vt[11] = '{1'b1, 4'b0001, 1'b0, 1'b1, 2'd0, 1'b0};
    vt[12] = '{1'b1, 4'b0001, 1'b0, 1'b1, 2'd0, 1'b0};
    vt[13] = '{1'b1, 4'b0001, 1'b0, 1'b1, 2'd0, 1'b0};
    vt[14] = '{1'b1, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b0};
    vt[15] = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0};
    vt[16] = '{1'b1, 4'b1000, 1'b0, 1'b1, 2'd3, 1'b0};
    vt[17] = '{1'b1, 4'b1000, 1'b0, 1'b1, 2'd3, 1'b0};
    vt[18] = '{1'b0, 4'b1000, 1'b0, 1'b0, 2'd0, 1'b0};
    vt[19] = '{1'b1, 4'b1111, 1'b0, 1'b1, 2'd0, 1'b0};
    vt[20] = '{1'b1, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0};
    vt[21] = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0};
    vt[22] = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0};

    for (int i = 0; i < NV; i++) begin
      rst_n    = vt[i].rst_n;
      bus.req  = vt[i].req;
      bus.done = vt[i].done;
      step();
      chk($sformatf("vec%0d_en", i), int'(bus.en), int'(vt[i].en));
      chk($sformatf("vec%0d_sel", i), cur_sel(), int'(vt[i].sel));
      chk($sformatf("vec%0d_timeout", i), int'(bus.timeout), int'(vt[i].to));
    end

    // Hold limit: channel 1 keeps requesting and never signals done.
    bus.done = 1'b0;
    bus.req  = 4'b0010;
    step();
    chk("to_grant_en", int'(bus.en), 1);
    chk("to_grant_sel", cur_sel(), 1);
    hi = 0;
    while (bus.en === 1'b1 && hi < 10) begin
      hi++;
      step();
    end
    chk("to_en_cycles", hi, 4);
    chk("to_pulse", int'(bus.timeout), 1);
    chk("to_sel_kept", cur_sel(), 1);
    step();
    chk("to_pulse_single", int'(bus.timeout), 0);
    chk("to_idle_en", int'(bus.en), 0);
    step();
    chk("to_regrant_en", int'(bus.en), 1);
    chk("to_regrant_sel", cur_sel(), 1);

    // Fairness with every channel requesting and done in the 3rd grant cycle.
    rst_n = 1'b0;
    step();
    rst_n   = 1'b1;
    bus.req = 4'b1111;
    exp_g   = '{0, 1, 2, 3, 0};
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (bus.en !== 1'b1 && n < 8) begin
        step();
        n++;
      end
      chk($sformatf("rr%0d_en", g), int'(bus.en), 1);
      chk($sformatf("rr%0d_sel", g), cur_sel(), exp_g[g]);
      if (g > 0) chk($sformatf("rr%0d_gap", g), n, 2);
      step();
      step();
      chk($sformatf("rr%0d_held", g), int'(bus.en), 1);
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      chk($sformatf("rr%0d_release", g), int'(bus.en), 0);
      chk($sformatf("rr%0d_timeout", g), int'(bus.timeout), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
